// File: rtl/mix_bus_accumulator.sv
// ---------------------------------------------------------------------------
// mix_bus_accumulator
//
// Sums saturated Q5.30 gain-multiplier products into independent mix buses.
// Products for up to NUM_BUSES buses arrive interleaved, one per beat, each
// tagged with a destination bus and first/last frame markers. When a bus's
// last term arrives, its frame total is saturated back to Q5.30 and presented
// on the registered output one cycle later, together with an overflow flag.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   reset_n       synchronous active-low reset
//   in_valid      a product beat is present this cycle (no backpressure)
//   in_data       Q5.30 product (DATA_WIDTH bits, two's complement)
//   in_bus        destination bus of the beat
//   in_first      beat starts a new frame on in_bus
//   in_last       beat ends the frame on in_bus
//   out_valid     one-cycle pulse: out_* carries a finished bus sum
//   out_bus       bus index of the finished sum
//   out_data      saturated Q5.30 frame sum
//   out_overflow  out_data was clamped
// ---------------------------------------------------------------------------
module mix_bus_accumulator #(
    parameter  int DATA_WIDTH = 36,
    parameter  int ACC_GUARD  = 4,
    parameter  int NUM_BUSES  = 8,
    localparam int BUS_W      = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [BUS_W-1:0]      in_bus,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [BUS_W-1:0]      out_bus,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_overflow
);

    // Accumulator width: guard bits absorb growth of up to 2^ACC_GUARD terms.
    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;

    // Saturate an accumulator value to DATA_WIDTH. Result is {overflow, data}.
    // The value fits when its top ACC_GUARD+1 bits are all copies of the sign.
    function automatic logic [DATA_WIDTH:0] sat_q530(input logic [ACC_W-1:0] v);
        logic [ACC_GUARD:0] top;
        logic [DATA_WIDTH:0] res;
        top = v[ACC_W-1:DATA_WIDTH-1];
        if ((top == {(ACC_GUARD+1){1'b0}}) || (top == {(ACC_GUARD+1){1'b1}})) begin
            res = {1'b0, v[DATA_WIDTH-1:0]};
        end else if (v[ACC_W-1] == 1'b0) begin
            res = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            res = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return res;
    endfunction

    // Sign-extend a product to accumulator width.
    function automatic logic [ACC_W-1:0] sext(input logic [DATA_WIDTH-1:0] d);
        return {{ACC_GUARD{d[DATA_WIDTH-1]}}, d};
    endfunction

    logic [ACC_W-1:0]      acc_q [NUM_BUSES];
    logic [ACC_W-1:0]      acc_d [NUM_BUSES];

    logic [ACC_W-1:0]      acc_sel_s;
    logic [ACC_W-1:0]      nxt_s;
    logic [DATA_WIDTH:0]   sat_s;

    logic                  out_valid_q,    out_valid_d;
    logic [BUS_W-1:0]      out_bus_q,      out_bus_d;
    logic [DATA_WIDTH-1:0] out_data_q,     out_data_d;
    logic                  out_overflow_q, out_overflow_d;

    // Running sum for this beat: a first term restarts the frame, otherwise
    // the term is added to the bus's partial sum in the same cycle, so
    // back-to-back beats on one bus need no forwarding or stall.
    always_comb begin
        acc_sel_s = acc_q[in_bus];
        if (in_first) begin
            nxt_s = sext(in_data);
        end else begin
            nxt_s = acc_sel_s + sext(in_data);
        end
        sat_s = sat_q530(nxt_s);
    end

    // Accumulator next state: only the addressed bus changes; a last beat
    // hands the sum to the output stage and clears the bus for its next frame.
    always_comb begin
        acc_d = acc_q;
        if (in_valid) begin
            if (in_last) begin
                acc_d[in_bus] = {ACC_W{1'b0}};
            end else begin
                acc_d[in_bus] = nxt_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output stage next state: pulse valid for one cycle after a last beat,
    // otherwise keep the previous bus/data/overflow.
    always_comb begin
        out_valid_d    = 1'b0;
        out_bus_d      = out_bus_q;
        out_data_d     = out_data_q;
        out_overflow_d = out_overflow_q;
        if (in_valid && in_last) begin
            out_valid_d    = 1'b1;
            out_bus_d      = in_bus;
            out_data_d     = sat_s[DATA_WIDTH-1:0];
            out_overflow_d = sat_s[DATA_WIDTH];
        end else begin
            out_valid_d    = 1'b0;
        end
    end

    // Accumulator registers with synchronous reset; reset discards partial sums.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUSES; i++) begin
                acc_q[i] <= {ACC_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_BUSES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q    <= 1'b0;
            out_bus_q      <= {BUS_W{1'b0}};
            out_data_q     <= {DATA_WIDTH{1'b0}};
            out_overflow_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_bus_q      <= out_bus_d;
            out_data_q     <= out_data_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_bus      = out_bus_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_mix_bus_accumulator.sv
module tb_mix_bus_accumulator;

    localparam int DW = 36;
    localparam int NB = 8;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [BW-1:0] in_bus;
    logic          in_first;
    logic          in_last;
    logic          out_valid;
    logic [BW-1:0] out_bus;
    logic [DW-1:0] out_data;
    logic          out_overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: exact integer frame sums per bus plus held output state.
    longint        model_sum [NB];
    int            term_cnt  [NB];
    logic          exp_valid;
    logic [BW-1:0] exp_bus;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;

    mix_bus_accumulator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_bus       (in_bus),
        .in_first     (in_first),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_bus      (out_bus),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    function automatic longint to_int(input logic [DW-1:0] d);
        logic signed [DW-1:0] s;
        s = d;
        return longint'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            model_sum[i] = 0;
            term_cnt[i]  = 0;
        end
        exp_valid = 1'b0;
        exp_bus   = '0;
        exp_data  = '0;
        exp_ovf   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
        chk({tag, ".bus"}, {61'd0, out_bus}, {61'd0, exp_bus});
        chk({tag, ".data"}, {28'd0, out_data}, {28'd0, exp_data});
        chk({tag, ".ovf"}, {63'd0, out_overflow}, {63'd0, exp_ovf});
    endtask

    // Apply one beat, update the model, clock it, then compare all outputs.
    task automatic beat(input string tag, input logic v, input logic [BW-1:0] b,
                        input logic f, input logic l, input logic [DW-1:0] d);
        longint s;
        in_valid = v; in_bus = b; in_first = f; in_last = l; in_data = d;
        exp_valid = 1'b0;
        if (v) begin
            s = f ? to_int(d) : model_sum[b] + to_int(d);
            if (l) begin
                model_sum[b] = 0;
                exp_valid = 1'b1;
                exp_bus   = b;
                if (s > 64'sh7_FFFF_FFFF) begin
                    exp_data = 36'h7_FFFF_FFFF; exp_ovf = 1'b1;
                end else if (s < -64'sh8_0000_0000) begin
                    exp_data = 36'h8_0000_0000; exp_ovf = 1'b1;
                end else begin
                    exp_data = s[DW-1:0]; exp_ovf = 1'b0;
                end
            end else begin
                model_sum[b] = s;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0; in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0]   r64;
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        logic          v, f, l;
        int            nc;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bus = '0;
        in_first = 1'b0; in_last = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset("reset");
        beat("idle", 1'b0, 3'd0, 1'b0, 1'b0, 36'h0);

        // Basic sum on bus 0 -> 3.5
        beat("basic0", 1'b1, 3'd0, 1'b1, 1'b0, 36'h0_4000_0000);
        beat("basic1", 1'b1, 3'd0, 1'b0, 1'b0, 36'h0_8000_0000);
        beat("basic2", 1'b1, 3'd0, 1'b0, 1'b1, 36'h0_2000_0000);
        chk("basic.const", {28'd0, out_data}, 64'h0_E000_0000);
        beat("basic.after", 1'b0, 3'd0, 1'b0, 1'b0, 36'h0);

        // Positive clamp on bus 3
        beat("pclamp0", 1'b1, 3'd3, 1'b1, 1'b0, 36'h7_C000_0000);
        beat("pclamp1", 1'b1, 3'd3, 1'b0, 1'b1, 36'h7_C000_0000);
        chk("pclamp.const", {27'd0, out_overflow, out_data}, {27'd0, 1'b1, 36'h7_FFFF_FFFF});

        // Negative clamp on bus 3
        beat("nclamp0", 1'b1, 3'd3, 1'b1, 1'b0, 36'h8_4000_0000);
        beat("nclamp1", 1'b1, 3'd3, 1'b0, 1'b1, 36'h8_4000_0000);
        chk("nclamp.const", {27'd0, out_overflow, out_data}, {27'd0, 1'b1, 36'h8_0000_0000});

        // Negative in-range result
        beat("neg0", 1'b1, 3'd4, 1'b1, 1'b0, 36'hF_C000_0000);
        beat("neg1", 1'b1, 3'd4, 1'b0, 1'b1, 36'h0_2000_0000);
        chk("neg.const", {27'd0, out_overflow, out_data}, {27'd0, 1'b0, 36'hF_E000_0000});

        // Interleaved buses 0 and 1
        beat("il0", 1'b1, 3'd0, 1'b1, 1'b0, 36'h0_4000_0000);
        beat("il1", 1'b1, 3'd1, 1'b1, 1'b0, 36'h0_1000_0000);
        beat("il2", 1'b1, 3'd0, 1'b0, 1'b1, 36'h0_4000_0000);
        chk("il.bus0", {25'd0, out_bus, out_data}, {25'd0, 3'd0, 36'h0_8000_0000});
        beat("il3", 1'b1, 3'd1, 1'b0, 1'b1, 36'h0_1000_0000);
        chk("il.bus1", {25'd0, out_bus, out_data}, {25'd0, 3'd1, 36'h0_2000_0000});

        // Single-term frame, then reset mid-frame
        beat("single", 1'b1, 3'd5, 1'b1, 1'b1, 36'h1_2345_6789);
        chk("single.const", {27'd0, out_overflow, out_data}, {27'd0, 1'b0, 36'h1_2345_6789});
        beat("mid0", 1'b1, 3'd2, 1'b1, 1'b0, 36'h0_4000_0000);
        do_reset("midreset");
        beat("mid1", 1'b1, 3'd2, 1'b0, 1'b1, 36'h0_4000_0000);
        chk("mid.const", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 36'h0_4000_0000});
        beat("mid.after", 1'b0, 3'd0, 1'b0, 1'b0, 36'h0);

        // Randomized interleaved frames, at most 16 terms each
        for (int i = 0; i < NB; i++) term_cnt[i] = 0;
        for (int n = 0; n < 800; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            b   = BW'($urandom_range(0, NB - 1));
            f   = ($urandom_range(0, 5) == 0);
            l   = ($urandom_range(0, 4) == 0);
            r64 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) d = r64[DW-1:0];
            else d = {{4{r64[31]}}, r64[31:0]};
            if (v) begin
                nc = f ? 1 : term_cnt[b] + 1;
                if (nc >= 16) l = 1'b1;
                term_cnt[b] = l ? 0 : nc;
            end
            beat("rand", v, b, f, l, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
